// File: rtl/mem_wb_if.sv
// MEM/WB stage interface: MEM-stage inputs plus stall/flush control, and WB-stage outputs.
//   master : MEM-stage / hazard-unit side (drives stall, flush, m_*; observes w_*)
//   slave  : the MEM/WB pipeline register (observes stall, flush, m_*; drives w_*)
//   stall, flush         hold / squash control for the WB stage
//   m_valid, m_wreg      MEM instruction is real / writes the register file
//   m_m2reg              write-back source select (1 = memory word, 0 = ALU result)
//   m_rd, m_alu, m_mem   destination index, ALU result, data-memory read word
//   w_valid, w_wreg      WB instruction is real / qualified register-file write enable
//   w_rd, w_data         register-file write index and data
//   w_retired            count of valid instructions loaded into WB
interface mem_wb_if #(
  parameter int unsigned DW    = 32,
  parameter int unsigned RW    = 5,
  parameter int unsigned CNT_W = 16
);
  logic             stall;
  logic             flush;
  logic             m_valid;
  logic             m_wreg;
  logic             m_m2reg;
  logic [RW-1:0]    m_rd;
  logic [DW-1:0]    m_alu;
  logic [DW-1:0]    m_mem;
  logic             w_valid;
  logic             w_wreg;
  logic [RW-1:0]    w_rd;
  logic [DW-1:0]    w_data;
  logic [CNT_W-1:0] w_retired;

  modport master (
    output stall, flush, m_valid, m_wreg, m_m2reg, m_rd, m_alu, m_mem,
    input  w_valid, w_wreg, w_rd, w_data, w_retired
  );

  modport slave (
    input  stall, flush, m_valid, m_wreg, m_m2reg, m_rd, m_alu, m_mem,
    output w_valid, w_wreg, w_rd, w_data, w_retired
  );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register of the 5-stage MIPS core.
// Captures the MEM-stage result one clock later, selects register-file write data,
// supports stall (hold) and flush (bubble), and counts retired instructions.
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   mem_wb_if.slave: stall/flush/m_* in, w_* out (outputs depend on registers only)
module mem_wb_pipe #(
  parameter int unsigned DW    = 32,
  parameter int unsigned RW    = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic     clk,
  input  logic     rst,
  mem_wb_if.slave  bus
);

  logic             valid_q;
  logic             wreg_q;
  logic             m2reg_q;
  logic [RW-1:0]    rd_q;
  logic [DW-1:0]    alu_q;
  logic [DW-1:0]    mem_q;
  logic [CNT_W-1:0] retired_q;

  // Priority flush > stall > load; flush only kills the control bits, payload holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      wreg_q    <= 1'b0;
      m2reg_q   <= 1'b0;
      rd_q      <= '0;
      alu_q     <= '0;
      mem_q     <= '0;
      retired_q <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      wreg_q  <= 1'b0;
    end else if (!bus.stall) begin
      valid_q   <= bus.m_valid;
      wreg_q    <= bus.m_wreg & bus.m_valid;
      m2reg_q   <= bus.m_m2reg;
      rd_q      <= bus.m_rd;
      alu_q     <= bus.m_alu;
      mem_q     <= bus.m_mem;
      retired_q <= retired_q + CNT_W'(bus.m_valid);
    end
  end

  // Register file write of $0 is suppressed here so WB never has to special-case it.
  assign bus.w_valid   = valid_q;
  assign bus.w_wreg    = valid_q & wreg_q & (rd_q != '0);
  assign bus.w_rd      = rd_q;
  assign bus.w_data    = m2reg_q ? mem_q : alu_q;
  assign bus.w_retired = retired_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: directed cases plus randomized traffic against
// a model that tracks the last accepted instruction and a retired count.
module tb_mem_wb_pipe;

  logic clk;
  logic rst;

  mem_wb_if #(.DW(32), .RW(5), .CNT_W(16)) bus ();
  mem_wb_if #(.DW(32), .RW(5), .CNT_W(4))  bus4 ();

  mem_wb_pipe #(.DW(32), .RW(5), .CNT_W(16)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  mem_wb_pipe #(.DW(32), .RW(5), .CNT_W(4))  u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  // Narrow-counter instance sees identical stimulus.
  assign bus4.stall   = bus.stall;
  assign bus4.flush   = bus.flush;
  assign bus4.m_valid = bus.m_valid;
  assign bus4.m_wreg  = bus.m_wreg;
  assign bus4.m_m2reg = bus.m_m2reg;
  assign bus4.m_rd    = bus.m_rd;
  assign bus4.m_alu   = bus.m_alu;
  assign bus4.m_mem   = bus.m_mem;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model: the last instruction accepted into WB, whether it is still live, and a retire count.
  logic        live;
  logic        l_wreg;
  logic        l_m2reg;
  logic [4:0]  l_rd;
  logic [31:0] l_alu;
  logic [31:0] l_mem;
  int unsigned n_retired;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    live = 1'b0; l_wreg = 1'b0; l_m2reg = 1'b0; l_rd = '0;
    l_alu = '0; l_mem = '0; n_retired = 0;
  endtask

  task automatic model_edge();
    if (bus.flush) begin
      live = 1'b0;
    end else if (!bus.stall) begin
      live    = bus.m_valid;
      l_wreg  = bus.m_wreg;
      l_m2reg = bus.m_m2reg;
      l_rd    = bus.m_rd;
      l_alu   = bus.m_alu;
      l_mem   = bus.m_mem;
      if (bus.m_valid) n_retired++;
    end
  endtask

  // Advance one clock; the model consumes the inputs present at that edge.
  task automatic step();
    @(posedge clk);
    if (rst) model_clear(); else model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input bit w, input bit m2, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input bit st, input bit fl);
    bus.m_valid = v; bus.m_wreg = w; bus.m_m2reg = m2; bus.m_rd = rd;
    bus.m_alu = alu; bus.m_mem = mem; bus.stall = st; bus.flush = fl;
  endtask

  task automatic drive_random();
    logic [4:0] rd;
    rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    drive(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), rd,
          $urandom, $urandom,
          ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) == 0));
  endtask

  // Reset asserted between edges must clear outputs immediately.
  task automatic mid_cycle_reset(input bit check_now);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    if (check_now) begin
      chk("rst_w_valid",   32'(bus.w_valid),   32'd0);
      chk("rst_w_wreg",    32'(bus.w_wreg),    32'd0);
      chk("rst_w_rd",      32'(bus.w_rd),      32'd0);
      chk("rst_w_data",    bus.w_data,         32'd0);
      chk("rst_w_retired", 32'(bus.w_retired), 32'd0);
    end
    step();
    rst = 1'b0;
  endtask

  // Every-cycle comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("w_valid",    32'(bus.w_valid),   32'(live));
        chk("w_wreg",     32'(bus.w_wreg),    32'(live && l_wreg && (l_rd != 5'd0)));
        chk("w_rd",       32'(bus.w_rd),      32'(l_rd));
        chk("w_data",     bus.w_data,         l_m2reg ? l_mem : l_alu);
        chk("w_retired",  32'(bus.w_retired), n_retired % 32'd65536);
        chk("w_retired4", 32'(bus4.w_retired), n_retired % 32'd16);
        chk("w_valid4",   32'(bus4.w_valid),  32'(live));
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 5'd0, 32'd0, 32'd0, 0, 0);
    model_clear();
    chk_en = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Some traffic, then a reset between edges.
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 0, 5'(i + 1), 32'(i + 100), 32'd0, 0, 0);
      step();
    end
    mid_cycle_reset(1'b1);

    // ALU path.
    drive(1, 1, 0, 5'd3, 32'h0000_00AA, 32'h1111_1111, 0, 0);
    step();
    chk("alu_w_wreg",    32'(bus.w_wreg),    32'd1);
    chk("alu_w_rd",      32'(bus.w_rd),      32'd3);
    chk("alu_w_data",    bus.w_data,         32'h0000_00AA);
    chk("alu_w_retired", 32'(bus.w_retired), 32'd1);

    // Load path, then distinct ALU/memory values to prove the mux direction.
    drive(1, 1, 1, 5'd8, 32'h0000_0005, 32'h0000_0005, 0, 0);
    step();
    chk("ld_w_data", bus.w_data,      32'h0000_0005);
    chk("ld_w_rd",   32'(bus.w_rd),   32'd8);
    chk("ld_w_wreg", 32'(bus.w_wreg), 32'd1);
    drive(1, 1, 1, 5'd9, 32'h1234_5678, 32'hDEAD_BEEF, 0, 0);
    step();
    chk("ld2_w_data", bus.w_data, 32'hDEAD_BEEF);
    drive(1, 1, 0, 5'd9, 32'h1234_5678, 32'hDEAD_BEEF, 0, 0);
    step();
    chk("alu2_w_data",    bus.w_data,         32'h1234_5678);
    chk("alu2_w_retired", 32'(bus.w_retired), 32'd4);

    // Writes to $0 are never enabled but still retire.
    drive(1, 1, 0, 5'd0, 32'h0000_0042, 32'd0, 0, 0);
    step();
    chk("r0_w_valid",   32'(bus.w_valid),   32'd1);
    chk("r0_w_wreg",    32'(bus.w_wreg),    32'd0);
    chk("r0_w_retired", 32'(bus.w_retired), 32'd5);

    // Invalid input loads a bubble.
    drive(0, 1, 0, 5'd4, 32'h0000_0044, 32'd0, 0, 0);
    step();
    chk("bub_w_valid",   32'(bus.w_valid),   32'd0);
    chk("bub_w_wreg",    32'(bus.w_wreg),    32'd0);
    chk("bub_w_data",    bus.w_data,         32'h0000_0044);
    chk("bub_w_retired", 32'(bus.w_retired), 32'd5);

    // Stall 3 cycles, then flush+stall together.
    drive(1, 1, 0, 5'd7, 32'h0000_0077, 32'd0, 0, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 5'(i + 20), $urandom, $urandom, 1, 0);
      step();
      chk("stl_w_valid",   32'(bus.w_valid),   32'd1);
      chk("stl_w_wreg",    32'(bus.w_wreg),    32'd1);
      chk("stl_w_rd",      32'(bus.w_rd),      32'd7);
      chk("stl_w_data",    bus.w_data,         32'h0000_0077);
      chk("stl_w_retired", 32'(bus.w_retired), 32'd6);
    end
    drive(1, 1, 1, 5'd30, 32'hFFFF_0000, 32'h0000_FFFF, 1, 1);
    step();
    chk("fl_w_valid",   32'(bus.w_valid),   32'd0);
    chk("fl_w_wreg",    32'(bus.w_wreg),    32'd0);
    chk("fl_w_rd",      32'(bus.w_rd),      32'd7);
    chk("fl_w_data",    bus.w_data,         32'h0000_0077);
    chk("fl_w_retired", 32'(bus.w_retired), 32'd6);

    // Narrow counter wraps 15 -> 0.
    mid_cycle_reset(1'b0);
    for (int i = 1; i <= 17; i++) begin
      drive(1, 1, 0, 5'd1, 32'(i), 32'd0, 0, 0);
      step();
      chk("wrap_w_retired4", 32'(bus4.w_retired), 32'(i % 16));
      chk("wrap_w_retired",  32'(bus.w_retired),  32'(i));
    end

    // Randomized traffic with occasional mid-cycle resets.
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      if ($urandom_range(0, 299) == 0) mid_cycle_reset(1'b1);
      else step();
    end

    drive(0, 0, 0, 5'd0, 32'd0, 32'd0, 0, 0);
    step();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
